// File: rtl/wb_timer16.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timer16
//  Description : WISHBONE 8-bit responder implementing a 16-bit timer/counter
//                with prescaler, compare match flag and level interrupt.
//                16-bit registers are accessed through a shared TEMP byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timer16 #(
  parameter logic [7:0] BASE_ADR = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ena_i,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       irq_req_o,
  input  logic       irq_ack_i
);

  localparam logic [2:0] OFS_CTRL  = 3'd0;
  localparam logic [2:0] OFS_STAT  = 3'd1;
  localparam logic [2:0] OFS_CNT_L = 3'd2;
  localparam logic [2:0] OFS_CNT_H = 3'd3;
  localparam logic [2:0] OFS_CMP_L = 3'd4;
  localparam logic [2:0] OFS_CMP_H = 3'd5;

  // ctrl = {IE, CTC, PS[1:0], RUN}
  logic [4:0]  ctrl;
  logic        mf;
  logic [15:0] cnt;
  logic [15:0] cmp;
  logic [7:0]  temp;
  logic [7:0]  presc;
  logic [7:0]  presc_top;
  logic [7:0]  rd_data;
  logic [2:0]  ofs;
  logic        sel, access, wr, rd;
  logic        tick, cnt_wr, ctrl_wr, match_set, mf_clr;

  assign ofs       = wb_adr_i[2:0];
  assign sel       = (wb_adr_i[7:3] == BASE_ADR[7:3]);
  // ack low is part of the qualifier so a held strobe yields a 1-cycle gap
  assign access    = wb_stb_i & sel & ~wb_ack_o;
  assign wr        = access & wb_we_i;
  assign rd        = access & ~wb_we_i;
  assign cnt_wr    = wr & (ofs == OFS_CNT_L);
  assign ctrl_wr   = wr & (ofs == OFS_CTRL);
  assign tick      = ctrl[0] & ena_i & (presc == presc_top);
  // A CPU write to CNT_L overrides any tick on the same edge, match included
  assign match_set = tick & ~cnt_wr & (cnt == cmp);
  assign mf_clr    = irq_ack_i | (wr & (ofs == OFS_STAT) & wb_dat_i[0]);
  assign irq_req_o = mf & ctrl[4];

  // Prescaler terminal value for the selected division ratio
  always_comb begin
    presc_top = 8'd0;
    case (ctrl[2:1])
      2'b00:   presc_top = 8'd0;
      2'b01:   presc_top = 8'd7;
      2'b10:   presc_top = 8'd63;
      default: presc_top = 8'd255;
    endcase
  end

  // Read data mux, sampled into wb_dat_o together with ack
  always_comb begin
    rd_data = 8'h00;
    case (ofs)
      OFS_CTRL:  rd_data = {3'b000, ctrl};
      OFS_STAT:  rd_data = {7'b0, mf};
      OFS_CNT_L: rd_data = cnt[7:0];
      OFS_CNT_H: rd_data = temp;
      OFS_CMP_L: rd_data = cmp[7:0];
      OFS_CMP_H: rd_data = temp;
      default:   rd_data = 8'h00;
    endcase
  end

  // Bus handshake: single-cycle registered ack, read data valid only with ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= rd ? rd_data : 8'h00;
    end
  end

  // Control register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ctrl <= 5'd0;
    else if (ctrl_wr) ctrl <= wb_dat_i[4:0];
  end

  // Prescaler: any CTRL write or counter load restarts the division period
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  presc <= 8'd0;
    else if (ctrl_wr || cnt_wr) presc <= 8'd0;
    else if (ctrl[0] && ena_i)  presc <= tick ? 8'd0 : presc + 8'd1;
  end

  // Counter: CPU load wins, otherwise advance or clear-on-match on tick
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    cnt <= 16'd0;
    else if (cnt_wr)              cnt <= {temp, wb_dat_i};
    else if (match_set && ctrl[3]) cnt <= 16'd0;
    else if (tick)                cnt <= cnt + 16'd1;
  end

  // Compare register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           cmp <= 16'hFFFF;
    else if (wr && (ofs == OFS_CMP_L))   cmp <= {temp, wb_dat_i};
  end

  // TEMP byte: latched by high-byte writes and low-byte reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                          temp <= 8'h00;
    else if (wr && (ofs == OFS_CNT_H || ofs == OFS_CMP_H)) temp <= wb_dat_i;
    else if (rd && (ofs == OFS_CNT_L))                  temp <= cnt[15:8];
    else if (rd && (ofs == OFS_CMP_L))                  temp <= cmp[15:8];
  end

  // Match flag: a set on the same edge as a clear takes priority
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          mf <= 1'b0;
    else if (match_set) mf <= 1'b1;
    else if (mf_clr)    mf <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_timer16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_timer16
//  Description : Self-checking bench for wb_timer16 (BASE_ADR = 8'h40).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_timer16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] wb_adr = 8'h00;
  logic [7:0] wb_dat_w = 8'h00;
  logic [7:0] wb_dat_r;
  logic       wb_stb = 1'b0;
  logic       wb_we = 1'b0;
  logic       wb_ack;
  logic       irq_req;
  logic       irq_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  wb_timer16 #(.BASE_ADR(8'h40)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ena_i     (ena),
    .wb_adr_i  (wb_adr),
    .wb_dat_i  (wb_dat_w),
    .wb_dat_o  (wb_dat_r),
    .wb_stb_i  (wb_stb),
    .wb_we_i   (wb_we),
    .wb_ack_o  (wb_ack),
    .irq_req_o (irq_req),
    .irq_ack_i (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] adr;
    logic       we;
    logic [7:0] wdat;
    logic       exp_ack;
    logic [7:0] exp_rdat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] adr, input logic we, input logic [7:0] wd,
                         input logic ea, input logic [7:0] er);
    vec_t v;
    v = '{adr, we, wd, ea, er};
    vecs.push_back(v);
  endtask

  // One bus transfer; optional single-cycle ena pulse aligned to the ack edge
  task automatic xfer(input logic [7:0] adr, input logic we, input logic [7:0] wd,
                      input logic tick_pulse, output logic [7:0] rdat,
                      output logic acked, output int waited);
    @(negedge clk);
    wb_adr = adr; wb_we = we; wb_dat_w = wd; wb_stb = 1'b1;
    if (tick_pulse) ena = 1'b1;
    acked = 1'b0; waited = 0; rdat = 8'h00;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      waited++;
      if (wb_ack) begin
        acked = 1'b1;
        rdat = wb_dat_r;
      end
    end
    wb_stb = 1'b0; wb_we = 1'b0;
    if (tick_pulse) ena = 1'b0;
    @(posedge clk);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [7:0] d);
    logic [7:0] r; logic a; int w;
    xfer(adr, 1'b1, d, 1'b0, r, a, w);
    chk($sformatf("wr_ack_%h", adr), {15'd0, a}, 16'd1);
  endtask

  task automatic rdc(input logic [7:0] adr, input logic [7:0] exp, input string nm);
    logic [7:0] r; logic a; int w;
    xfer(adr, 1'b0, 8'h00, 1'b0, r, a, w);
    chk({nm, "_ack"}, {15'd0, a}, 16'd1);
    chk(nm, {8'd0, r}, {8'd0, exp});
  endtask

  // Exactly k rising edges with ena high
  task automatic run_cycles(input int k);
    @(negedge clk);
    ena = 1'b1;
    repeat (k) @(negedge clk);
    ena = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       a;
    int         w;

    // Register-map vectors at BASE_ADR = 8'h40, ena held low
    add_vec(8'h40, 0, 8'h00, 1, 8'h00);
    add_vec(8'h41, 0, 8'h00, 1, 8'h00);
    add_vec(8'h42, 0, 8'h00, 1, 8'h00);
    add_vec(8'h43, 0, 8'h00, 1, 8'h00);
    add_vec(8'h44, 0, 8'h00, 1, 8'hFF);
    add_vec(8'h45, 0, 8'h00, 1, 8'hFF);
    add_vec(8'h48, 0, 8'h00, 0, 8'h00);
    add_vec(8'h43, 1, 8'h12, 1, 8'h00);
    add_vec(8'h42, 1, 8'h34, 1, 8'h00);
    add_vec(8'h42, 0, 8'h00, 1, 8'h34);
    add_vec(8'h43, 0, 8'h00, 1, 8'h12);
    add_vec(8'h43, 1, 8'hAB, 1, 8'h00);
    add_vec(8'h42, 0, 8'h00, 1, 8'h34);
    add_vec(8'h43, 0, 8'h00, 1, 8'h12);
    add_vec(8'h4A, 1, 8'h55, 0, 8'h00);
    add_vec(8'h42, 0, 8'h00, 1, 8'h34);
    add_vec(8'h46, 0, 8'h00, 1, 8'h00);
    add_vec(8'h47, 1, 8'hFF, 1, 8'h00);
    add_vec(8'h47, 0, 8'h00, 1, 8'h00);
    add_vec(8'h40, 1, 8'hFF, 1, 8'h00);
    add_vec(8'h40, 0, 8'h00, 1, 8'h1F);
    add_vec(8'h40, 1, 8'h00, 1, 8'h00);
    add_vec(8'h40, 0, 8'h00, 1, 8'h00);
    add_vec(8'h41, 0, 8'h00, 1, 8'h00);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {15'd0, wb_ack}, 16'd0);
    chk("rst_dat", {8'd0, wb_dat_r}, 16'd0);
    chk("rst_irq", {15'd0, irq_req}, 16'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, 1'b0, r, a, w);
      chk($sformatf("vec%0d_ack", i), {15'd0, a}, {15'd0, vecs[i].exp_ack});
      if (vecs[i].exp_ack) begin
        chk($sformatf("vec%0d_lat", i), w[15:0], 16'd1);
        chk($sformatf("vec%0d_dat", i), {8'd0, r}, {8'd0, vecs[i].exp_rdat});
      end
    end

    // Strobe held across ack: 1,0,1,0
    @(negedge clk);
    wb_adr = 8'h40; wb_we = 1'b0; wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ack%0d", i), {15'd0, wb_ack}, (i % 2 == 0) ? 16'd1 : 16'd0);
    end
    wb_stb = 1'b0;
    @(posedge clk);

    // CTC with compare 0003
    wr(8'h45, 8'h00); wr(8'h44, 8'h03);
    wr(8'h43, 8'h00); wr(8'h42, 8'h00);
    wr(8'h40, 8'h19);
    chk("ctc_irq0", {15'd0, irq_req}, 16'd0);
    run_cycles(1); rdc(8'h42, 8'h01, "ctc_c1");
    run_cycles(1); rdc(8'h42, 8'h02, "ctc_c2");
    run_cycles(1); rdc(8'h42, 8'h03, "ctc_c3");
    chk("ctc_irq_c3", {15'd0, irq_req}, 16'd0);
    rdc(8'h41, 8'h00, "ctc_stat_c3");
    run_cycles(1); rdc(8'h42, 8'h00, "ctc_c0");
    chk("ctc_irq_match", {15'd0, irq_req}, 16'd1);
    rdc(8'h41, 8'h01, "ctc_stat_match");
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    chk("irq_ack_clr", {15'd0, irq_req}, 16'd0);
    rdc(8'h41, 8'h00, "stat_after_ack");

    // Prescaler /8
    wr(8'h40, 8'h00);
    wr(8'h43, 8'h00); wr(8'h42, 8'h00);
    wr(8'h40, 8'h03);
    run_cycles(7); rdc(8'h42, 8'h00, "ps8_7clk");
    run_cycles(1); rdc(8'h42, 8'h01, "ps8_8clk");
    wr(8'h43, 8'h00); wr(8'h42, 8'h00);
    run_cycles(4);
    repeat (5) @(negedge clk);
    run_cycles(3); rdc(8'h42, 8'h00, "ps8_frozen7");
    run_cycles(1); rdc(8'h42, 8'h01, "ps8_frozen8");

    // Wrap through FFFF with CTC off
    wr(8'h40, 8'h00);
    wr(8'h45, 8'hFF); wr(8'h44, 8'hFF);
    wr(8'h43, 8'hFF); wr(8'h42, 8'hFE);
    wr(8'h40, 8'h11);
    rdc(8'h41, 8'h00, "wrap_stat0");
    run_cycles(1);
    rdc(8'h42, 8'hFF, "wrap_t1_l"); rdc(8'h43, 8'hFF, "wrap_t1_h");
    rdc(8'h41, 8'h00, "wrap_t1_stat");
    run_cycles(1);
    rdc(8'h42, 8'h00, "wrap_t2_l"); rdc(8'h43, 8'h00, "wrap_t2_h");
    rdc(8'h41, 8'h01, "wrap_t2_stat");
    chk("wrap_irq", {15'd0, irq_req}, 16'd1);
    wr(8'h41, 8'h00); rdc(8'h41, 8'h01, "stat_wr0");
    wr(8'h41, 8'h01); rdc(8'h41, 8'h00, "stat_wr1");
    chk("stat_wr1_irq", {15'd0, irq_req}, 16'd0);

    // Set wins over irq_ack on the same edge
    wr(8'h45, 8'h00); wr(8'h44, 8'h00);
    @(negedge clk); ena = 1'b1; irq_ack = 1'b1;
    @(negedge clk); ena = 1'b0; irq_ack = 1'b0;
    chk("setwins_irq", {15'd0, irq_req}, 16'd1);
    rdc(8'h41, 8'h01, "setwins_stat");
    rdc(8'h42, 8'h01, "setwins_cnt");

    // CNT_L write on a tick edge: CPU value, no increment, no match
    wr(8'h41, 8'h01);
    wr(8'h45, 8'h00); wr(8'h44, 8'h01);
    wr(8'h43, 8'h00);
    xfer(8'h42, 1'b1, 8'h05, 1'b1, r, a, w);
    chk("tickwr_ack", {15'd0, a}, 16'd1);
    rdc(8'h42, 8'h05, "tickwr_cnt");
    rdc(8'h41, 8'h00, "tickwr_stat");

    // CNT_L read on a tick edge: pre-edge value and high byte
    wr(8'h43, 8'h01); wr(8'h42, 8'hFF);
    xfer(8'h42, 1'b0, 8'h00, 1'b1, r, a, w);
    chk("tickrd_l", {8'd0, r}, 16'h00FF);
    rdc(8'h43, 8'h01, "tickrd_h");
    rdc(8'h42, 8'h00, "tickrd_l2");
    rdc(8'h43, 8'h02, "tickrd_h2");

    // Reset in the middle of a CNT_L read
    wr(8'h45, 8'h02); wr(8'h44, 8'h00);
    run_cycles(1);
    chk("prerst_irq", {15'd0, irq_req}, 16'd1);
    @(negedge clk);
    wb_adr = 8'h42; wb_we = 1'b0; wb_stb = 1'b1;
    @(posedge clk); #1;
    chk("prerst_ack", {15'd0, wb_ack}, 16'd1);
    #2; rst = 1'b1; #1;
    chk("midrst_ack", {15'd0, wb_ack}, 16'd0);
    chk("midrst_irq", {15'd0, irq_req}, 16'd0);
    chk("midrst_dat", {8'd0, wb_dat_r}, 16'd0);
    @(negedge clk); rst = 1'b0;
    a = 1'b0; w = 0; r = 8'h00;
    for (int i = 0; i < 4 && !a; i++) begin
      @(posedge clk); #1;
      w++;
      if (wb_ack) begin a = 1'b1; r = wb_dat_r; end
    end
    wb_stb = 1'b0;
    @(posedge clk);
    chk("postrst_ack", {15'd0, a}, 16'd1);
    chk("postrst_lat", w[15:0], 16'd1);
    chk("postrst_l", {8'd0, r}, 16'd0);
    rdc(8'h43, 8'h00, "postrst_h");
    rdc(8'h44, 8'hFF, "postrst_cmpl");
    rdc(8'h45, 8'hFF, "postrst_cmph");
    rdc(8'h40, 8'h00, "postrst_ctrl");
    rdc(8'h41, 8'h00, "postrst_stat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
